// File: rtl/fpu_frbus_retire_if.sv
// FPU result bus: producer pushes, register-file writeback and fflags CSR.
// slave is the retire block, master is the surrounding environment.
interface fpu_frbus_retire_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) ();
   logic              dp_frbus_ex2_vld;
   logic [DATA_W-1:0] dp_frbus_ex2_data;
   logic [4:0]        dp_frbus_ex2_fflags;
   logic [REG_AW-1:0] dp_frbus_ex2_rd;
   logic              frbus_dp_stall;
   logic              fdsu_frbus_vld;
   logic [DATA_W-1:0] fdsu_frbus_data;
   logic [4:0]        fdsu_frbus_fflags;
   logic [REG_AW-1:0] fdsu_frbus_rd;
   logic              frbus_fdsu_rdy;
   logic              frbus_rf_wb_vld;
   logic [DATA_W-1:0] frbus_rf_wb_data;
   logic [REG_AW-1:0] frbus_rf_wb_rd;
   logic              rf_frbus_wb_rdy;
   logic              csr_fflags_wen;
   logic [4:0]        csr_fflags_wdata;
   logic [4:0]        frbus_csr_fflags;
   logic              frbus_ovfl_err;

   modport slave (
      input  dp_frbus_ex2_vld, dp_frbus_ex2_data,
      input  dp_frbus_ex2_fflags, dp_frbus_ex2_rd,
      output frbus_dp_stall,
      input  fdsu_frbus_vld, fdsu_frbus_data,
      input  fdsu_frbus_fflags, fdsu_frbus_rd,
      output frbus_fdsu_rdy,
      output frbus_rf_wb_vld, frbus_rf_wb_data, frbus_rf_wb_rd,
      input  rf_frbus_wb_rdy,
      input  csr_fflags_wen, csr_fflags_wdata,
      output frbus_csr_fflags, frbus_ovfl_err
   );

   modport master (
      output dp_frbus_ex2_vld, dp_frbus_ex2_data,
      output dp_frbus_ex2_fflags, dp_frbus_ex2_rd,
      input  frbus_dp_stall,
      output fdsu_frbus_vld, fdsu_frbus_data,
      output fdsu_frbus_fflags, fdsu_frbus_rd,
      input  frbus_fdsu_rdy,
      input  frbus_rf_wb_vld, frbus_rf_wb_data, frbus_rf_wb_rd,
      output rf_frbus_wb_rdy,
      output csr_fflags_wen, csr_fflags_wdata,
      input  frbus_csr_fflags, frbus_ovfl_err
   );
endinterface

// File: rtl/fpu_frbus_retire.sv
// FPU result-bus retire: in-order result FIFO feeding the FP regfile
// write port, with sticky fflags accrual at retirement.
module fpu_frbus_retire #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 4
) (
   input logic          forever_cpuclk,
   input logic          cpurst_b,
   fpu_frbus_retire_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = DATA_W + 5 + REG_AW;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [4:0]    fflags_q, fflags_d;
   logic          ovfl_q, ovfl_d;

   logic          wb_vld, full, pop, room;
   logic          dp_push, fdsu_rdy, push;
   logic [EW-1:0] head, push_ent;
   logic [4:0]    csr_base, ret_flags;

   always_comb begin
      wb_vld    = (cnt_q != '0);
      full      = (cnt_q == FULL_CNT);
      head      = mem_q[rd_ptr_q];
      pop       = wb_vld & bus.rf_frbus_wb_rdy;
      // A pop frees the slot this cycle, so a full FIFO can still accept.
      room      = !full | pop;
      dp_push   = bus.dp_frbus_ex2_vld & room;
      fdsu_rdy  = bus.fdsu_frbus_vld & !bus.dp_frbus_ex2_vld & room;
      push      = dp_push | fdsu_rdy;
      push_ent  = bus.dp_frbus_ex2_vld
                ? {bus.dp_frbus_ex2_data, bus.dp_frbus_ex2_fflags,
                   bus.dp_frbus_ex2_rd}
                : {bus.fdsu_frbus_data, bus.fdsu_frbus_fflags,
                   bus.fdsu_frbus_rd};
      rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      csr_base  = bus.csr_fflags_wen ? bus.csr_fflags_wdata : fflags_q;
      ret_flags = pop ? head[REG_AW +: 5] : 5'b0;
      fflags_d  = csr_base | ret_flags;
      ovfl_d    = ovfl_q | (bus.dp_frbus_ex2_vld & !room);
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         fflags_q <= '0;
         ovfl_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         fflags_q <= fflags_d;
         ovfl_q   <= ovfl_d;
      end
   end

   // Storage is not reset; count gates visibility of stale entries.
   always_ff @(posedge forever_cpuclk) begin
      if (push) mem_q[wr_ptr_q] <= push_ent;
   end

   assign bus.frbus_dp_stall   = full;
   assign bus.frbus_fdsu_rdy   = fdsu_rdy;
   assign bus.frbus_rf_wb_vld  = wb_vld;
   assign bus.frbus_rf_wb_data = wb_vld ? head[EW-1 -: DATA_W] : '0;
   assign bus.frbus_rf_wb_rd   = wb_vld ? head[REG_AW-1:0] : '0;
   assign bus.frbus_csr_fflags = fflags_q;
   assign bus.frbus_ovfl_err   = ovfl_q;
endmodule
